// File: rtl/ctrl_unit_pipe.sv
// ctrl_unit_pipe: registered decode-stage control unit.
// Decodes the opcode into an ID/EX control word with a valid/ready handshake,
// freeze/flush control and a multi-cycle MUL sequencer.
// Optional feature macro: ILLEGAL_OPC_EN adds a sticky illegal_op output.
module ctrl_unit_pipe #(
  parameter int unsigned OPC_W   = 6,
  parameter int unsigned EXEC_W  = 5,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned MUL_OPC = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [OPC_W-1:0]  opcode,
  output logic              in_ready,
  input  logic              freeze,
  input  logic              flush,
  output logic              out_valid,
  output logic [EXEC_W-1:0] exec_cmd,
  output logic              is_imm,
  output logic              MEM_R_EN,
  output logic              MEM_W_EN,
  output logic              WB_EN,
  output logic              st_or_bne,
  output logic              is_jmp,
  output logic              is_br,
  output logic              br_type,
  output logic              busy
`ifdef ILLEGAL_OPC_EN
  ,
  output logic              illegal_op
`endif
);

  localparam int unsigned CntW = $clog2(MUL_LAT + 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  typedef struct packed {
    logic [EXEC_W-1:0] exec_cmd;
    logic              is_imm;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              wb_en;
    logic              st_or_bne;
    logic              is_jmp;
    logic              is_br;
    logic              br_type;
  } ctrl_t;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            valid_q, valid_d;
  ctrl_t           word_q, word_d;
  ctrl_t           dec;
  ctrl_t           mul_word;
  logic            accept;
  logic            is_mul;

  assign accept = in_valid & in_ready;
  assign is_mul = (opcode == OPC_W'(MUL_OPC));

  // Opcode decode; unlisted opcodes fall through to an all-zero NOP word.
  always_comb begin
    dec = '0;
    case (opcode)
      OPC_W'(1):  begin dec.exec_cmd = EXEC_W'(0); dec.wb_en = 1'b1; end
      OPC_W'(3):  begin dec.exec_cmd = EXEC_W'(1); dec.wb_en = 1'b1; end
      OPC_W'(5):  begin dec.exec_cmd = EXEC_W'(2); dec.wb_en = 1'b1; end
      OPC_W'(6):  begin dec.exec_cmd = EXEC_W'(3); dec.wb_en = 1'b1; end
      OPC_W'(7):  begin dec.exec_cmd = EXEC_W'(4); dec.wb_en = 1'b1; end
      OPC_W'(8):  begin dec.exec_cmd = EXEC_W'(5); dec.wb_en = 1'b1; end
      OPC_W'(9):  begin dec.exec_cmd = EXEC_W'(6); dec.wb_en = 1'b1; end
      OPC_W'(10): begin dec.exec_cmd = EXEC_W'(7); dec.wb_en = 1'b1; end
      OPC_W'(11): begin dec.exec_cmd = EXEC_W'(8); dec.wb_en = 1'b1; end
      OPC_W'(12): begin dec.exec_cmd = EXEC_W'(9); dec.wb_en = 1'b1; end
      OPC_W'(MUL_OPC): begin dec.exec_cmd = EXEC_W'(10); dec.wb_en = 1'b1; end
      OPC_W'(32): begin
        dec.is_imm = 1'b1;
        dec.wb_en  = 1'b1;
      end
      OPC_W'(33): begin
        dec.exec_cmd = EXEC_W'(1);
        dec.is_imm   = 1'b1;
        dec.wb_en    = 1'b1;
      end
      OPC_W'(36): begin
        dec.is_imm   = 1'b1;
        dec.mem_r_en = 1'b1;
        dec.wb_en    = 1'b1;
      end
      OPC_W'(37): begin
        dec.is_imm    = 1'b1;
        dec.mem_w_en  = 1'b1;
        dec.st_or_bne = 1'b1;
      end
      OPC_W'(40): begin
        dec.exec_cmd = EXEC_W'(14);
        dec.is_imm   = 1'b1;
        dec.is_br    = 1'b1;
        dec.br_type  = 1'b1;
      end
      OPC_W'(41): begin
        dec.exec_cmd  = EXEC_W'(15);
        dec.is_imm    = 1'b1;
        dec.st_or_bne = 1'b1;
        dec.is_br     = 1'b1;
      end
      OPC_W'(42): begin
        dec.exec_cmd = EXEC_W'(16);
        dec.is_imm   = 1'b1;
        dec.is_jmp   = 1'b1;
      end
      default: dec = '0;
    endcase
  end

  // Control word issued when the MUL sequencer completes.
  always_comb begin
    mul_word          = '0;
    mul_word.exec_cmd = EXEC_W'(10);
    mul_word.wb_en    = 1'b1;
  end

  // FSM state and MUL countdown register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: flush wins over freeze; freeze holds everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (!freeze) begin
      unique case (state_q)
        StIdle: begin
          if (accept && is_mul && (MUL_LAT > 1)) begin
            state_d = StBusy;
            cnt_d   = CntW'(MUL_LAT - 1);
          end
        end
        StBusy: begin
          if (cnt_q == CntW'(1)) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM outputs: handshake, busy, and the next registered control word.
  always_comb begin
    in_ready = (state_q == StIdle) & ~freeze;
    busy     = (state_q == StBusy);
    valid_d  = valid_q;
    word_d   = word_q;
    if (flush) begin
      valid_d = 1'b0;
      word_d  = '0;
    end else if (!freeze) begin
      unique case (state_q)
        StIdle: begin
          valid_d = 1'b0;
          word_d  = '0;
          // A MUL with latency 1 issues like any single-cycle op.
          if (accept && !(is_mul && (MUL_LAT > 1))) begin
            valid_d = 1'b1;
            word_d  = dec;
          end
        end
        StBusy: begin
          if (cnt_q == CntW'(1)) begin
            valid_d = 1'b1;
            word_d  = mul_word;
          end
        end
        default: begin
          valid_d = 1'b0;
          word_d  = '0;
        end
      endcase
    end
  end

  // ID/EX control word register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end

  assign out_valid = valid_q;
  assign exec_cmd  = word_q.exec_cmd;
  assign is_imm    = word_q.is_imm;
  assign MEM_R_EN  = word_q.mem_r_en;
  assign MEM_W_EN  = word_q.mem_w_en;
  assign WB_EN     = word_q.wb_en;
  assign st_or_bne = word_q.st_or_bne;
  assign is_jmp    = word_q.is_jmp;
  assign is_br     = word_q.is_br;
  assign br_type   = word_q.br_type;

`ifdef ILLEGAL_OPC_EN
  logic dec_legal;
  logic ill_q, ill_d;

  assign dec_legal = opcode inside {OPC_W'(0), OPC_W'(1), OPC_W'(3), OPC_W'(5), OPC_W'(6),
                                    OPC_W'(7), OPC_W'(8), OPC_W'(9), OPC_W'(10), OPC_W'(11),
                                    OPC_W'(12), OPC_W'(MUL_OPC), OPC_W'(32), OPC_W'(33),
                                    OPC_W'(36), OPC_W'(37), OPC_W'(40), OPC_W'(41),
                                    OPC_W'(42)};

  // Sticky flag: a flushed cycle drops its opcode, so it cannot set the flag.
  always_comb begin
    ill_d = ill_q | (accept & ~flush & ~dec_legal);
  end

  // Illegal-opcode flag register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ill_q <= 1'b0;
    end else begin
      ill_q <= ill_d;
    end
  end

  assign illegal_op = ill_q;
`endif

endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// Self-checking bench for ctrl_unit_pipe with a behavioural reference model.
module tb_ctrl_unit_pipe;

  localparam int unsigned OPC_W   = 6;
  localparam int unsigned EXEC_W  = 5;
  localparam int unsigned MUL_LAT = 3;
  localparam int unsigned MUL_OPC = 13;

  typedef struct packed {
    logic [4:0] cmd;
    logic imm, mr, mw, wb, sob, jmp, br, bt;
  } word_t;

  logic clk = 1'b0;
  logic rst, in_valid, freeze, flush;
  logic [OPC_W-1:0] opcode;
  logic in_ready, out_valid, busy;
  logic [EXEC_W-1:0] exec_cmd;
  logic is_imm, MEM_R_EN, MEM_W_EN, WB_EN, st_or_bne, is_jmp, is_br, br_type;
`ifdef ILLEGAL_OPC_EN
  logic illegal_op;
`endif
  word_t dut_word;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit    m_valid;
  word_t m_word;
  int    m_pend;
  bit    m_ill;

  ctrl_unit_pipe #(
    .OPC_W(OPC_W), .EXEC_W(EXEC_W), .MUL_LAT(MUL_LAT), .MUL_OPC(MUL_OPC)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .in_ready(in_ready),
    .freeze(freeze), .flush(flush), .out_valid(out_valid), .exec_cmd(exec_cmd),
    .is_imm(is_imm), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN),
    .st_or_bne(st_or_bne), .is_jmp(is_jmp), .is_br(is_br), .br_type(br_type),
    .busy(busy)
`ifdef ILLEGAL_OPC_EN
    , .illegal_op(illegal_op)
`endif
  );

  assign dut_word = {exec_cmd, is_imm, MEM_R_EN, MEM_W_EN, WB_EN, st_or_bne, is_jmp, is_br,
                     br_type};

  always #5 clk = ~clk;

  function automatic word_t ref_dec(input int op);
    word_t w = '0;
    if (op == 1 || op == 3 || op inside {[5:12]}) begin
      w.wb  = 1'b1;
      w.cmd = 5'((op == 1) ? 0 : (op == 3) ? 1 : op - 3);
    end else if (op == MUL_OPC) begin
      w.wb  = 1'b1;
      w.cmd = 5'd10;
    end else begin
      case (op)
        32: begin w.imm = 1; w.wb = 1; end
        33: begin w.imm = 1; w.wb = 1; w.cmd = 5'd1; end
        36: begin w.imm = 1; w.wb = 1; w.mr = 1; end
        37: begin w.imm = 1; w.mw = 1; w.sob = 1; end
        40: begin w.imm = 1; w.br = 1; w.bt = 1; w.cmd = 5'd14; end
        41: begin w.imm = 1; w.br = 1; w.sob = 1; w.cmd = 5'd15; end
        42: begin w.imm = 1; w.jmp = 1; w.cmd = 5'd16; end
        default: w = '0;
      endcase
    end
    return w;
  endfunction

  function automatic bit ref_illegal(input int op);
    return !(op == 0 || op == 1 || op == 3 || op inside {[5:12]} || op == MUL_OPC ||
             op inside {32, 33, 36, 37, 40, 41, 42});
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit rdy;
    rdy = (m_pend == 0) && !freeze;
    if (flush) begin
      m_valid = 0; m_word = '0; m_pend = 0;
    end else if (!freeze) begin
      if (m_pend > 0) begin
        m_pend--;
        m_valid = (m_pend == 0);
        m_word  = (m_pend == 0) ? ref_dec(MUL_OPC) : '0;
      end else if (in_valid && rdy) begin
        if (opcode == OPC_W'(MUL_OPC) && MUL_LAT > 1) begin
          m_pend = MUL_LAT - 1; m_valid = 0; m_word = '0;
        end else begin
          m_valid = 1; m_word = ref_dec(int'(opcode));
          if (ref_illegal(int'(opcode))) m_ill = 1;
        end
      end else begin
        m_valid = 0; m_word = '0;
      end
    end
  endtask

  task automatic drive(input bit v, input int op, input bit fz, input bit fl);
    in_valid = v; opcode = OPC_W'(op); freeze = fz; flush = fl;
    #1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0);
    m_valid = 0; m_word = '0; m_pend = 0; m_ill = 0;
    #12;
    n_tests++;
    if ({out_valid, dut_word, busy} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0", {out_valid, dut_word, busy});
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int ops[6]     = '{1, 32, 36, 37, 40, 42};
    int exp_cmd[6] = '{0, 0, 0, 0, 14, 16};
    bit exp_wb[6]  = '{1, 1, 1, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      drive(1, ops[i], 0, 0);
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready op=%0d got=%b exp=1", ops[i], in_ready);
      end
      tick();
      n_tests++;
      if ({out_valid, dut_word} !== {m_valid, m_word} || int'(exec_cmd) != exp_cmd[i] ||
          WB_EN !== exp_wb[i] || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_word op=%0d got=%h exp=%h cmd_exp=%0d wb_exp=%0d", ops[i],
                 {out_valid, dut_word}, {m_valid, m_word}, exp_cmd[i], exp_wb[i]);
      end
    end
    drive(0, 0, 0, 0);
    tick();
  endtask

  task automatic test_mul();
    int edges;
    drive(1, MUL_OPC, 0, 0);
    tick();
    edges = 1;
    drive(0, 0, 0, 0);
    while (out_valid !== 1'b1 && edges < 20) begin
      n_tests++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL mul_stall edge=%0d got ready=%b busy=%b exp ready=0 busy=1", edges,
                 in_ready, busy);
      end
      tick();
      edges++;
    end
    n_tests++;
    if (edges != MUL_LAT || exec_cmd !== 5'd10 || WB_EN !== 1'b1 || busy !== 1'b0 ||
        {out_valid, dut_word} !== {m_valid, m_word}) begin
      n_fail++;
      $display("FAIL mul_issue got edges=%0d cmd=%0d wb=%b exp edges=%0d cmd=10 wb=1", edges,
               exec_cmd, WB_EN, MUL_LAT);
    end
    drive(1, 3, 0, 0);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_next_ready got=%b exp=1", in_ready);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || exec_cmd !== 5'd1) begin
      n_fail++;
      $display("FAIL mul_next_issue got v=%b cmd=%0d exp v=1 cmd=1", out_valid, exec_cmd);
    end
    drive(0, 0, 0, 0);
    tick();
  endtask

  task automatic test_freeze_mul();
    logic [14:0] snap;
    drive(1, MUL_OPC, 0, 0);
    tick();
    drive(0, 0, 1, 0);
    snap = {out_valid, dut_word, busy};
    for (int e = 2; e <= 5; e++) begin
      if (e == 4) drive(0, 0, 0, 0);
      tick();
      n_tests++;
      if ((e <= 3 && {out_valid, dut_word, busy} !== snap) || out_valid !== (e == 5) ||
          {out_valid, dut_word, busy} !== {m_valid, m_word, m_pend != 0}) begin
        n_fail++;
        $display("FAIL freeze_mul edge=%0d got=%h exp=%h", e, {out_valid, dut_word, busy},
                 {m_valid, m_word, m_pend != 0});
      end
    end
    drive(0, 0, 0, 0);
    tick();
  endtask

  task automatic test_flush();
    drive(1, 1, 0, 0);
    tick();
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pre got=%b exp=1", out_valid);
    end
    drive(1, 1, 0, 1);
    tick();
    n_tests++;
    if ({out_valid, dut_word} !== 14'd0) begin
      n_fail++;
      $display("FAIL flush_drop got=%h exp=0", {out_valid, dut_word});
    end
    drive(1, MUL_OPC, 0, 0);
    tick();
    drive(0, 0, 0, 1);
    tick();
    n_tests++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_busy got busy=%b ready=%b exp busy=0 ready=1", busy, in_ready);
    end
    drive(0, 0, 0, 0);
    for (int i = 0; i < MUL_LAT + 1; i++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_no_mul cyc=%0d got=%b exp=0", i, out_valid);
      end
    end
  endtask

  task automatic test_illegal();
    drive(1, 63, 0, 0);
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || dut_word !== '0) begin
      n_fail++;
      $display("FAIL illegal_nop got=%h exp=%h", {out_valid, dut_word}, 14'h2000);
    end
`ifdef ILLEGAL_OPC_EN
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (illegal_op !== 1'b1) begin
        n_fail++;
        $display("FAIL illegal_sticky step=%0d got=%b exp=1", i, illegal_op);
      end
      drive(1, 1 + 4 * i, 0, 0);
      tick();
    end
`endif
    drive(0, 0, 0, 0);
    tick();
  endtask

  task automatic test_async_reset_busy();
    drive(1, MUL_OPC, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre got busy=%b exp=1", busy);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({out_valid, dut_word, busy} !== 15'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_mid got=%h ready=%b exp=0 ready=1", {out_valid, dut_word, busy},
               in_ready);
    end
`ifdef ILLEGAL_OPC_EN
    n_tests++;
    if (illegal_op !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_illegal got=%b exp=0", illegal_op);
    end
`endif
    m_valid = 0; m_word = '0; m_pend = 0; m_ill = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    int pool[12] = '{0, 1, 3, 12, 13, 32, 33, 36, 37, 40, 41, 42};
    int op;
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 63))
                                       : pool[$urandom_range(0, 11)];
      drive(bit'($urandom_range(0, 1)), op, $urandom_range(0, 4) == 0,
            $urandom_range(0, 11) == 0);
      n_tests++;
      if (in_ready !== ((m_pend == 0) && !freeze)) begin
        n_fail++;
        $display("FAIL rand_ready cyc=%0d got=%b exp=%b", i, in_ready,
                 (m_pend == 0) && !freeze);
      end
      tick();
      n_tests++;
      if ({out_valid, dut_word, busy} !== {m_valid, m_word, m_pend != 0}) begin
        n_fail++;
        $display("FAIL rand_word cyc=%0d op=%0d got=%h exp=%h", i, op,
                 {out_valid, dut_word, busy}, {m_valid, m_word, m_pend != 0});
      end
`ifdef ILLEGAL_OPC_EN
      n_tests++;
      if (illegal_op !== m_ill) begin
        n_fail++;
        $display("FAIL rand_illegal cyc=%0d got=%b exp=%b", i, illegal_op, m_ill);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mul();
    test_freeze_mul();
    test_flush();
    test_illegal();
    test_async_reset_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_unit_pipe.md
Name: ctrl_unit_pipe

Overview:
Parametrised, registered successor of the decode-stage control unit. Decodes the 6-bit-class opcode into exec command and stage-enable signals, then registers them as the ID/EX control word. Adds a valid/ready handshake, freeze/flush pipeline control, and a multi-cycle MUL sequencer that holds fetch/decode while the multiply is pending. Sits between the instruction decode logic and the EX stage.

Parameters:
OPC_W, 6, opcode width
EXEC_W, 5, exec_cmd width; must hold 16 (BEZ/BNE/JMP codes 14/15/16)
MUL_LAT, 3, cycles from MUL accept to MUL control word valid; range 1..15
MUL_OPC, 13, opcode value of MUL

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  opcode valid from decode
opcode  in  OPC_W  instruction opcode
in_ready  out  1  block can accept an opcode this cycle
freeze  in  1  downstream stall; hold all registered outputs
flush  in  1  branch/jump flush; kill the current and pending control word
out_valid  out  1  registered control word valid
exec_cmd  out  EXEC_W  ALU command
is_imm, MEM_R_EN, MEM_W_EN, WB_EN, st_or_bne, is_jmp, is_br, br_type  out  1 each  registered control bits
busy  out  1  MUL sequencer active

Behaviour:
- Decode (combinational, internal): ADD1→0, SUB3→1, AND5→2, OR6→3, NOR7→4, XOR8→5, SLA9→6, SLL10→7, SRA11→8, SRL12→9, MUL_OPC→10, ADDI32→0, SUBI33→1, LD36→0, ST37→0, BEZ40→14, BNE41→15, JMP42→16; exec_cmd zero-extended to EXEC_W.
- is_imm: 32,33,36,37,40,41,42. MEM_R_EN: 36. MEM_W_EN: 37. st_or_bne: 37,41. is_jmp: 42. is_br: 40,41. br_type: 40.
- WB_EN: ALU ops 1,3,5..12, MUL, 32,33,36. Opcode 0 (NOP) and any unlisted opcode decode as NOP: all bits 0, exec_cmd 0, WB_EN 0.
- Reset: all outputs 0 except in_ready=1; state IDLE; counter 0.
- in_ready = (state==IDLE) & ~freeze. Accept = in_valid & in_ready.
- Priority per edge: rst > flush > freeze > normal.
- flush: next edge out_valid=0, control bits cleared to 0, state→IDLE, counter→0; in_valid in the flush cycle is dropped even if in_ready=1.
- freeze (no flush): every register holds, counter does not decrement.
- IDLE, accept, non-MUL: next edge loads decoded word, out_valid=1 (latency 1).
- IDLE, no accept: next edge out_valid=0, control bits 0 (bubble).
- IDLE, accept MUL, MUL_LAT=1: same as non-MUL.
- IDLE, accept MUL, MUL_LAT>1: →BUSY, counter=MUL_LAT-1, out_valid=0 with bits 0, busy=1.
- BUSY: each unfrozen edge decrements the counter. When counter==1, the edge loads the MUL word, out_valid=1, state→IDLE, busy=0. MUL word is valid exactly MUL_LAT edges after accept, plus any frozen cycles.
- Counter width $clog2(MUL_LAT+1); no wrap, since it only loads from IDLE.

Optional Feature:
ILLEGAL_OPC_EN. Defined: adds output illegal_op (1 bit). It is a sticky flag, set on the edge that accepts an opcode not in the decode list and not 0. It is cleared only by rst. The illegal opcode still issues as a NOP with out_valid=1. Undefined: the port is absent and illegal opcodes silently decode as NOP.

Test Plan:
- rst pulse mid-BUSY (async, between edges) -> outputs 0 immediately, in_ready=1, busy=0.
- Back-to-back in_valid with opcodes 1,32,36,37,40,42 -> one edge later each: exec_cmd 0,0,0,0,14,16; WB_EN 1,1,1,0,0,0; MEM_R_EN only for 36; st_or_bne only for 37; is_br/br_type=1/1 for 40; is_jmp for 42.
- MUL (13), MUL_LAT=3 -> in_ready=0 for 2 cycles, out_valid=1 with exec_cmd=10, WB_EN=1 on the 3rd edge; next opcode accepted the following cycle.
- freeze held 2 cycles during MUL BUSY -> MUL word appears at the 5th edge; outputs stable while frozen.
- flush with in_valid=1 opcode 1 while out_valid=1 -> next edge out_valid=0; flush during BUSY -> busy=0, no MUL word issued.
- Opcode 63 with ILLEGAL_OPC_EN defined -> out_valid=1, all bits 0, illegal_op=1 and stays 1 through later legal ops.
